// File: rtl/hazard_ctrl.sv
// Hazard controller beside the ID/EX boundary: in-flight destination scoreboard,
// registered EX forwarding selects, load-use stall, branch squash and HLT drain.
module hazard_ctrl #(
    parameter int RW           = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_we,
    input  logic          id_load,
    input  logic          id_hlt,
    input  logic          ex_br_taken,
    output logic          stall,
    output logic          bubble,
    output logic          flush,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          halted
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    // Invalid slots are stored as all-zero, so a nonzero slot means in flight.
    typedef struct packed {
        logic          v;
        logic          we;
        logic [RW-1:0] rd;
        logic          load;
    } slot_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    slot_t         ex_slot, mem_slot, wb_slot;

    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic load_use, hlt_go, issue, pipe_busy;

    function automatic logic hit(input logic used, input logic [RW-1:0] src, input slot_t s);
        return used && (src != '0) && s.v && s.we && (s.rd == src);
    endfunction

    function automatic logic [1:0] sel(input logic h_ex, input logic h_mem);
        if (h_ex)
            return 2'b01;
        else if (h_mem)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign hit_ex_a  = hit(id_use_rs, id_rs, ex_slot);
    assign hit_ex_b  = hit(id_use_rt, id_rt, ex_slot);
    assign hit_mem_a = hit(id_use_rs, id_rs, mem_slot);
    assign hit_mem_b = hit(id_use_rt, id_rt, mem_slot);
    assign pipe_busy = (ex_slot != '0) || (mem_slot != '0) || (wb_slot != '0);
    assign issue     = id_valid && !bubble && !flush;
    assign halted    = (state == HALTED);

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        load_use   = 1'b0;
        hlt_go     = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    flush    = ex_br_taken;
                    load_use = id_valid && !ex_br_taken && ex_slot.load && (hit_ex_a || hit_ex_b);
                    hlt_go   = id_valid && id_hlt && !load_use && !ex_br_taken;
                    stall    = load_use || hlt_go;
                    bubble   = load_use || ex_br_taken || hlt_go;
                    if (hlt_go)
                        next_state = DRAIN;
                end
                DRAIN: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (cnt == '0 && !pipe_busy)
                        next_state = HALTED;
                end
                HALTED: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            cnt      <= '0;
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
            fwd_a    <= 2'b00;
            fwd_b    <= 2'b00;
        end else begin
            state    <= next_state;
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            if (hlt_go)
                cnt <= CW'(DRAIN_CYCLES - 1);
            else if (state == DRAIN && cnt != '0)
                cnt <= cnt - 1'b1;
            if (issue) begin
                ex_slot <= '{v: 1'b1, we: id_we, rd: id_rd, load: id_load};
                fwd_a   <= sel(hit_ex_a, hit_mem_a);
                fwd_b   <= sel(hit_ex_b, hit_mem_b);
            end else begin
                ex_slot <= '0;
                fwd_a   <= 2'b00;
                fwd_b   <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed and random instruction streams, an age-ordered
// history model producing expectations into a queue, and a negedge monitor.
module tb_hazard_ctrl;

    localparam int RW = 4;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs, id_use_rt, id_we, id_load, id_hlt, ex_br_taken;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          stall, bubble, flush, halted;
    logic [1:0]    fwd_a, fwd_b;

    always #5 clk = ~clk;

    hazard_ctrl #(.RW(RW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_we(id_we),
        .id_load(id_load), .id_hlt(id_hlt), .ex_br_taken(ex_br_taken),
        .stall(stall), .bubble(bubble), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted)
    );

    // Issued-instruction history, newest first: entry 0 is one stage ahead (EX), 1 is two (MEM).
    typedef struct {
        bit v;
        bit we;
        int rd;
        bit ld;
    } rec_t;

    rec_t       hist[$];
    logic [7:0] exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         halt_at = -1;
    logic [1:0] m_fa = 2'b00;
    logic [1:0] m_fb = 2'b00;

    function automatic bit produces(rec_t r, bit used, int src);
        return used && src != 0 && r.v && r.we && r.rd == src;
    endfunction

    // Youngest older producer wins; distance 1 -> 01, distance 2 -> 10.
    function automatic logic [1:0] pick(bit used, int src);
        for (int d = 0; d < 2; d++)
            if (produces(hist[d], used, src))
                return (d == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_model();
        rec_t inv;
        inv = '{v: 0, we: 0, rd: 0, ld: 0};
        hist = {inv, inv, inv};
        m_fa = 2'b00;
        m_fb = 2'b00;
        halt_at = -1;
    endtask

    task automatic check(string name, logic [1:0] act, logic [1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Drive one ID-stage cycle, record the expected outputs, advance the model.
    task automatic step(input bit r, input bit v, input int rs, input int rt,
                        input bit urs, input bit urt, input int rd, input bit we,
                        input bit ld, input bit hl, input bit br);
        bit   st, bb, fl, hd, dr, lu, hg, iss;
        rec_t nr;
        rst = r; id_valid = v; id_rs = rs[RW-1:0]; id_rt = rt[RW-1:0];
        id_use_rs = urs; id_use_rt = urt; id_rd = rd[RW-1:0]; id_we = we;
        id_load = ld; id_hlt = hl; ex_br_taken = br;

        hd = (halt_at >= 0) && (cyc > halt_at + DC);
        dr = (halt_at >= 0) && (cyc > halt_at) && !hd;
        st = 0; bb = 0; fl = 0; hg = 0; lu = 0;
        if (r) begin
            if (hd || dr) begin
                st = 1; bb = 1;
            end else begin
                fl = br;
                lu = !br && v && hist[0].ld && (produces(hist[0], urs, rs) || produces(hist[0], urt, rt));
                hg = v && hl && !lu && !br;
                st = lu || hg;
                bb = lu || br || hg;
            end
        end
        exp_q.push_back({st, bb, fl, m_fa, m_fb, hd});

        if (!r) begin
            clear_model();
        end else begin
            iss = v && !bb;
            m_fa = iss ? pick(urs, rs) : 2'b00;
            m_fb = iss ? pick(urt, rt) : 2'b00;
            nr = iss ? '{v: 1, we: we, rd: rd, ld: ld} : '{v: 0, we: 0, rd: 0, ld: 0};
            hist.push_front(nr);
            void'(hist.pop_back());
            if (hg)
                halt_at = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares whatever the driver expected for the cycle now on the pins.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall",  {1'b0, stall},  {1'b0, e[7]});
                check("bubble", {1'b0, bubble}, {1'b0, e[6]});
                check("flush",  {1'b0, flush},  {1'b0, e[5]});
                check("fwd_a",  fwd_a,          e[4:3]);
                check("fwd_b",  fwd_b,          e[2:1]);
                check("halted", {1'b0, halted}, {1'b0, e[0]});
            end
        end
    end

    initial begin
        clear_model();
        rst = 0; id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        id_rd = '0; id_we = 0; id_load = 0; id_hlt = 0; ex_br_taken = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then back-to-back ALU forwarding: ADD R3, SUB R4<-R3,R5, XOR R6<-R3,R3.
        nop();
        step(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        step(1, 1, 3, 5, 1, 1, 4, 1, 0, 0, 0);
        step(1, 1, 3, 3, 1, 1, 6, 1, 0, 0, 0);
        nop(); nop();

        // Load-use: LW R7, consumer reads rt=R7 (held through the stall).
        step(1, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
        step(1, 1, 2, 7, 1, 1, 8, 1, 0, 0, 0);
        step(1, 1, 2, 7, 1, 1, 8, 1, 0, 0, 0);
        nop(); nop();

        // R0 is never forwarded.
        step(1, 1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1, 1, 4, 1, 0, 0, 0);
        nop(); nop();

        // Taken branch overrides a pending load-use stall.
        step(1, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
        step(1, 1, 7, 7, 1, 1, 9, 1, 0, 0, 1);
        nop(); nop();

        // HLT squashed by a taken branch in the same cycle.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        nop(); nop();

        // HLT with three older instructions in flight: drain, halt, hold, reset.
        step(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        step(1, 1, 3, 2, 1, 1, 4, 1, 1, 0, 0);
        step(1, 1, 5, 6, 1, 1, 5, 1, 0, 0, 0);
        repeat (8) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(); nop();

        // Random streams with dense register reuse, occasional branches, HLTs and resets.
        for (int i = 0; i < 600; i++) begin
            bit r;
            r = ($urandom_range(0, 39) != 0);
            if (halt_at >= 0 && cyc > halt_at + DC + 3)
                r = 0;
            step(r, ($urandom_range(0, 99) < 85),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 7) == 0));
        end
        nop();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
